// File: rtl/mem_access.sv
// mem_access: MIPS memory stage. Turns EX/MEM outputs into a req/ack data-memory access,
// stalls while it is outstanding and drives MEM/WB. Define MEM_ACCESS_TIMEOUT_EN for the BUSY watchdog and o_timeout.
`timescale 1ns/1ps
module mem_access #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_nrst,
   input  logic [31:0] i_data_alures,
   input  logic [31:0] i_data_rt,
   input  logic [4:0]  i_addr_regdst,
   input  logic        i_con_Mmemread,
   input  logic        i_con_Mmemwrite,
   input  logic [1:0]  i_con_Wloadmux,
   input  logic        i_con_Wmemtoreg,
   input  logic        i_con_Wregwrite,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_be,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata,
   output logic        o_stall,
   output logic        o_misalign,
   output logic [31:0] o_data_FMalures,
   output logic [4:0]  o_addr_FMregdst,
   output logic        o_con_FMregwrite,
   output logic [31:0] o_data_alures,
   output logic [31:0] o_data_memrd,
   output logic [4:0]  o_addr_regdst,
   output logic        o_con_Wmemtoreg,
`ifdef MEM_ACCESS_TIMEOUT_EN
   output logic        o_timeout,
`endif
   output logic        o_con_Wregwrite
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t      state_q, state_d;

   logic        is_mem;
   logic        aligned;
   logic        access;
   logic        misalign;
   logic        abort;
   logic        load_done;
   logic [1:0]  lane;
   logic [31:0] load_data;

   logic [31:0] alures_q, alures_d;
   logic [31:0] memrd_q, memrd_d;
   logic [4:0]  regdst_q, regdst_d;
   logic        memtoreg_q, memtoreg_d;
   logic        regwrite_q, regwrite_d;
   logic        misalign_q, misalign_d;

   // Little-endian lane extraction with sign/zero extension chosen by loadmux.
   function automatic logic [31:0] fmt_load(input logic [31:0] rdata,
                                            input logic [1:0]  ln,
                                            input logic [1:0]  lmux);
      logic signed [15:0] half;
      logic signed [7:0]  byt;
      logic [31:0]        shifted;
      logic [31:0]        res;
      half    = ln[1] ? rdata[31:16] : rdata[15:0];
      shifted = rdata >> {ln, 3'b000};
      byt     = shifted[7:0];
      case (lmux)
         2'b00:   res = rdata;
         2'b01:   res = {{16{half[15]}}, half};
         2'b10:   res = {{24{byt[7]}}, byt};
         default: res = {24'd0, byt};
      endcase
      return res;
   endfunction

   // Stores replicate the datum across all lanes; byte enables pick the lane.
   function automatic logic [31:0] fmt_store(input logic [31:0] rt,
                                             input logic [1:0]  lmux);
      logic [31:0] res;
      case (lmux)
         2'b00:   res = rt;
         2'b01:   res = {2{rt[15:0]}};
         default: res = {4{rt[7:0]}};
      endcase
      return res;
   endfunction

   function automatic logic [3:0] byte_en(input logic [1:0] ln,
                                          input logic [1:0] lmux);
      logic [3:0] res;
      case (lmux)
         2'b00:   res = 4'b1111;
         2'b01:   res = ln[1] ? 4'b1100 : 4'b0011;
         default: res = 4'b0001 << ln;
      endcase
      return res;
   endfunction

   assign lane   = i_data_alures[1:0];
   assign is_mem = i_con_Mmemread | i_con_Mmemwrite;

   always_comb begin
      case (i_con_Wloadmux)
         2'b00:   aligned = (lane == 2'b00);
         2'b01:   aligned = ~lane[0];
         default: aligned = 1'b1;
      endcase
   end

   assign access    = is_mem & aligned;
   assign misalign  = is_mem & ~aligned;
   // A read-modify combination (memread & memwrite) is a store, so it never returns load data.
   assign load_done = access & i_con_Mmemread & ~i_con_Mmemwrite & i_mem_ack;
   assign load_data = fmt_load(i_mem_rdata, lane, i_con_Wloadmux);

   assign o_mem_addr  = {i_data_alures[31:2], 2'b00};
   assign o_mem_wdata = fmt_store(i_data_rt, i_con_Wloadmux);
   assign o_mem_be    = byte_en(lane, i_con_Wloadmux);
   assign o_mem_we    = i_con_Mmemwrite;

   assign o_data_FMalures  = i_data_alures;
   assign o_addr_FMregdst  = i_addr_regdst;
   assign o_con_FMregwrite = i_con_Wregwrite;

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   assign abort = (state_q == S_BUSY) & ~i_mem_ack &
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q | abort;
      if (state_q == S_IDLE && state_d == S_BUSY) begin
         cnt_d = '0;
      end else if (state_q == S_BUSY) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_timeout = timeout_q;
`else
   assign abort = 1'b0;
`endif

   // FSM: state register
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (access && !i_mem_ack) state_d = S_BUSY;
         S_BUSY: if (i_mem_ack || abort)   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs; gated by reset so an aborted request drops without waiting for a clock.
   always_comb begin
      o_mem_req = 1'b0;
      o_stall   = 1'b0;
      case (state_q)
         S_IDLE: begin
            o_mem_req = i_nrst & access;
            o_stall   = i_nrst & access & ~i_mem_ack;
         end
         S_BUSY: begin
            o_mem_req = i_nrst & ~abort;
            o_stall   = i_nrst & access & ~i_mem_ack & ~abort;
         end
         default: begin
            o_mem_req = 1'b0;
            o_stall   = 1'b0;
         end
      endcase
   end

   // MEM/WB: a stalled cycle writes a bubble so the held instruction retires exactly once.
   always_comb begin
      alures_d   = alures_q;
      memrd_d    = memrd_q;
      regdst_d   = regdst_q;
      memtoreg_d = 1'b0;
      regwrite_d = 1'b0;
      misalign_d = misalign;
      if (!o_stall) begin
         alures_d   = i_data_alures;
         memrd_d    = load_done ? load_data : 32'd0;
         regdst_d   = i_addr_regdst;
         memtoreg_d = i_con_Wmemtoreg;
         regwrite_d = i_con_Wregwrite & ~misalign & ~abort;
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         alures_q   <= 32'd0;
         memrd_q    <= 32'd0;
         regdst_q   <= 5'd0;
         memtoreg_q <= 1'b0;
         regwrite_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         alures_q   <= alures_d;
         memrd_q    <= memrd_d;
         regdst_q   <= regdst_d;
         memtoreg_q <= memtoreg_d;
         regwrite_q <= regwrite_d;
         misalign_q <= misalign_d;
      end
   end

   assign o_data_alures   = alures_q;
   assign o_data_memrd    = memrd_q;
   assign o_addr_regdst   = regdst_q;
   assign o_con_Wmemtoreg = memtoreg_q;
   assign o_con_Wregwrite = regwrite_q;
   assign o_misalign      = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: scoreboard of expected MEM/WB entries plus immediate checks on the memory port.
`timescale 1ns/1ps
module tb_mem_access;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [31:0] alures, rt, rdata;
   logic [4:0]  regdst;
   logic        mrd, mwr, m2r, rw, ack;
   logic [1:0]  lmux;
   logic        req, we, stall, misal, fm_rw, wb_m2r, wb_rw;
   logic [31:0] maddr, wdata, fm_alures, wb_alures, wb_memrd;
   logic [3:0]  be;
   logic [4:0]  fm_regdst, wb_regdst;
`ifdef MEM_ACCESS_TIMEOUT_EN
   logic        tmo;
`endif

   typedef struct packed {
      logic [31:0] alures;
      logic [31:0] memrd;
      logic [4:0]  regdst;
      logic        m2r;
      logic        rw;
   } wb_t;

   wb_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   always #5 clk = ~clk;

   mem_access #(.TIMEOUT_CYCLES(255)) dut (
      .i_clk(clk), .i_nrst(nrst),
      .i_data_alures(alures), .i_data_rt(rt), .i_addr_regdst(regdst),
      .i_con_Mmemread(mrd), .i_con_Mmemwrite(mwr), .i_con_Wloadmux(lmux),
      .i_con_Wmemtoreg(m2r), .i_con_Wregwrite(rw),
      .o_mem_req(req), .o_mem_we(we), .o_mem_addr(maddr), .o_mem_wdata(wdata),
      .o_mem_be(be), .i_mem_ack(ack), .i_mem_rdata(rdata),
      .o_stall(stall), .o_misalign(misal),
      .o_data_FMalures(fm_alures), .o_addr_FMregdst(fm_regdst), .o_con_FMregwrite(fm_rw),
      .o_data_alures(wb_alures), .o_data_memrd(wb_memrd), .o_addr_regdst(wb_regdst),
      .o_con_Wmemtoreg(wb_m2r),
`ifdef MEM_ACCESS_TIMEOUT_EN
      .o_timeout(tmo),
`endif
      .o_con_Wregwrite(wb_rw)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_instr(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                            input logic rd, input logic wr, input logic [1:0] lm,
                            input logic mt, input logic w);
      alures = a; rt = d; regdst = r; mrd = rd; mwr = wr; lmux = lm; m2r = mt; rw = w;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] m, input logic [4:0] r,
                       input logic mt, input logic w);
      wb_t e;
      e.alures = a; e.memrd = m; e.regdst = r; e.m2r = mt; e.rw = w;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pop_check(input string tag);
      wb_t e;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_alures"},   wb_alures, e.alures);
         chk({tag, "_memrd"},    wb_memrd,  e.memrd);
         chk({tag, "_regdst"},   wb_regdst, 32'(e.regdst));
         chk({tag, "_memtoreg"}, wb_m2r,    32'(e.m2r));
         chk({tag, "_regwrite"}, wb_rw,     32'(e.rw));
      end
   endtask

   initial begin
      set_instr(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      ack = 1'b0; rdata = 32'd0; nrst = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("rst_req", req, 0);      chk("rst_stall", stall, 0);  chk("rst_misalign", misal, 0);
      chk("rst_alures", wb_alures, 0); chk("rst_memrd", wb_memrd, 0);
      chk("rst_regdst", wb_regdst, 0); chk("rst_m2r", wb_m2r, 0); chk("rst_rw", wb_rw, 0);
      nrst = 1'b1;

      // ALU instruction: forwarding is immediate, MEM/WB one cycle later
      set_instr(32'h55, 32'd0, 5'd9, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
      #1;
      chk("add_fm_alures", fm_alures, 32'h55); chk("add_fm_regdst", fm_regdst, 9);
      chk("add_fm_rw", fm_rw, 1); chk("add_req", req, 0); chk("add_stall", stall, 0);
      push(32'h55, 32'd0, 5'd9, 1'b0, 1'b1);
      tick(); pop_check("add");

      // sw with zero-wait ack
      set_instr(32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      ack = 1'b1;
      #1;
      chk("sw_req", req, 1); chk("sw_we", we, 1); chk("sw_be", be, 4'b1111);
      chk("sw_addr", maddr, 32'h100); chk("sw_wdata", wdata, 32'hDEADBEEF); chk("sw_stall", stall, 0);
      push(32'h100, 32'd0, 5'd0, 1'b0, 1'b0);
      tick(); pop_check("sw"); ack = 1'b0;

      // lb signed at 0x103, ack after three stalled cycles
      set_instr(32'h103, 32'd0, 5'd5, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
      #1;
      chk("lb_req", req, 1); chk("lb_we", we, 0); chk("lb_be", be, 4'b1000); chk("lb_addr", maddr, 32'h100);
      push(32'h103, 32'hFFFFFF80, 5'd5, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("lb_stall", stall, 1);
         chk("lb_busy_req", req, 1);
         tick();
         chk("lb_bubble_rw", wb_rw, 0); chk("lb_bubble_m2r", wb_m2r, 0);
         chk("lb_bubble_alures_held", wb_alures, 32'h100);
      end
      ack = 1'b1; rdata = 32'h80123456;
      #1;
      chk("lb_ack_stall", stall, 0);
      tick(); pop_check("lb"); ack = 1'b0;

      // sh at 0x206: upper half lane
      set_instr(32'h206, 32'h1234, 5'd0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
      ack = 1'b1;
      #1;
      chk("sh_wdata", wdata, 32'h12341234); chk("sh_be", be, 4'b1100); chk("sh_req", req, 1);
      push(32'h206, 32'd0, 5'd0, 1'b0, 1'b0);
      tick(); pop_check("sh");

      // lh signed at 0x206
      set_instr(32'h206, 32'd0, 5'd7, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
      rdata = 32'hABCD0000;
      #1;
      chk("lh_be", be, 4'b1100);
      push(32'h206, 32'hFFFFABCD, 5'd7, 1'b1, 1'b1);
      tick(); pop_check("lh");

      // lbu at 0x101: zero-extended lane 1
      set_instr(32'h101, 32'd0, 5'd8, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
      rdata = 32'h0000F200;
      #1;
      chk("lbu_be", be, 4'b0010);
      push(32'h101, 32'h000000F2, 5'd8, 1'b1, 1'b1);
      tick(); pop_check("lbu");

      // lw at 0x104
      set_instr(32'h104, 32'd0, 5'd6, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
      rdata = 32'hCAFEF00D;
      #1;
      chk("lw_addr", maddr, 32'h104);
      push(32'h104, 32'hCAFEF00D, 5'd6, 1'b1, 1'b1);
      tick(); pop_check("lw");

      // sb at 0x102
      set_instr(32'h102, 32'h5A5A01AB, 5'd0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
      #1;
      chk("sb_wdata", wdata, 32'hABABABAB); chk("sb_be", be, 4'b0100); chk("sb_we", we, 1);
      push(32'h102, 32'd0, 5'd0, 1'b0, 1'b0);
      tick(); pop_check("sb");

      // memread and memwrite together behave as a store
      set_instr(32'h200, 32'h11223344, 5'd2, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
      rdata = 32'hFFFFFFFF;
      #1;
      chk("rw_we", we, 1); chk("rw_wdata", wdata, 32'h11223344); chk("rw_be", be, 4'b1111);
      push(32'h200, 32'd0, 5'd2, 1'b1, 1'b1);
      tick(); pop_check("rdwr"); ack = 1'b0;

      // misaligned lw at 0x101
      set_instr(32'h101, 32'd0, 5'd3, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
      #1;
      chk("mis_lw_req", req, 0); chk("mis_lw_stall", stall, 0);
      push(32'h101, 32'd0, 5'd3, 1'b1, 1'b0);
      tick(); pop_check("mis_lw"); chk("mis_lw_pulse", misal, 1);

      // misaligned sh at 0x203
      set_instr(32'h203, 32'h77, 5'd0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
      #1;
      chk("mis_sh_req", req, 0); chk("mis_sh_stall", stall, 0);
      push(32'h203, 32'd0, 5'd0, 1'b0, 1'b0);
      tick(); pop_check("mis_sh"); chk("mis_sh_pulse", misal, 1);

      // stray ack with no request is ignored
      set_instr(32'h77, 32'd0, 5'd4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
      ack = 1'b1;
      #1;
      chk("stray_req", req, 0); chk("stray_stall", stall, 0);
      push(32'h77, 32'd0, 5'd4, 1'b0, 1'b1);
      tick(); pop_check("stray"); chk("stray_misalign_clear", misal, 0);
      ack = 1'b0;

      // reset while BUSY drops the request at once
      set_instr(32'h300, 32'd0, 5'd11, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
      tick();
      chk("busy_req", req, 1); chk("busy_stall", stall, 1);
      nrst = 1'b0;
      #1;
      chk("rstbusy_req", req, 0); chk("rstbusy_stall", stall, 0);
      chk("rstbusy_alures", wb_alures, 0); chk("rstbusy_memrd", wb_memrd, 0);
      chk("rstbusy_regdst", wb_regdst, 0); chk("rstbusy_m2r", wb_m2r, 0); chk("rstbusy_rw", wb_rw, 0);
      @(negedge clk);
      set_instr(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      nrst = 1'b1;
      #1;
      chk("after_rst_idle_req", req, 0);
      tick();
      chk("after_rst_idle_req2", req, 0);

`ifdef MEM_ACCESS_TIMEOUT_EN
      begin
         int cyc;
         cyc = 0;
         chk("tmo_initial", tmo, 0);
         set_instr(32'h400, 32'd0, 5'd12, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
         #1;
         while (stall && cyc < 400) begin
            tick();
            cyc++;
         end
         chk("tmo_stall_cycles", cyc, 255);
         chk("tmo_abort_req", req, 0);
         tick();
         chk("tmo_flag", tmo, 1); chk("tmo_rw", wb_rw, 0); chk("tmo_memrd", wb_memrd, 0);
         set_instr(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
         tick();
         chk("tmo_sticky", tmo, 1); chk("tmo_idle_req", req, 0);
      end
`endif

      chk("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
